wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back stage plus architectural register file. It consumes the registered outputs of the memory/write-back pipeline register and selects the write-back value. It writes the selected value into a 32 x 32-bit integer register file and serves the two decode-stage read ports, with write-through bypass. It also exports the write-back result for EX forwarding and keeps a retired-instruction counter.

Parameters:
XLEN, 32, data width of registers and write-back values
NREG, 32, number of architectural registers (address width = clog2(NREG) = 5)
CNT_W, 64, width of the retired-instruction counter

Ports:
sys_clk  input  1  system clock, all state on rising edge
sys_rst  input  1  asynchronous, active-high reset
wb_valid_i  input  1  a real instruction is present in write-back this cycle (0 = bubble)
ALU_result_i  input  XLEN  ALU result from the pipeline register
DataMemReadData_i  input  XLEN  load data from the pipeline register
pc_link_i  input  XLEN  link address (already pc+4) for jumps
RD_addr_i  input  5  destination register
RegWrite_i  input  1  register write enable
MemToReg_i  input  1  select load data
isjump_i  input  1  select link address
rs1_addr_i  input  5  read port 1 address
rs2_addr_i  input  5  read port 2 address
rs1_data_o  output  XLEN  read port 1 data (combinational)
rs2_data_o  output  XLEN  read port 2 data (combinational)
fwd_we_o  output  1  forwarding: write-back will commit this cycle
fwd_addr_o  output  5  forwarding: destination register
fwd_data_o  output  XLEN  forwarding: selected write-back value
instret_o  output  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous and active-high. While sys_rst = 1, all NREG registers are 0 and instret_o = 0. Read and forwarding outputs stay purely combinational during reset, so rs*_data_o = 0.
- Write-back select, fixed priority:
  - isjump_i = 1 -> pc_link_i
  - else MemToReg_i = 1 -> DataMemReadData_i
  - else -> ALU_result_i
  - Result is fwd_data_o.
- Commit condition: we = wb_valid_i & RegWrite_i & (RD_addr_i != 0).
  - fwd_we_o = we; fwd_addr_o = RD_addr_i.
  - fwd_data_o is driven even when we = 0. Consumers must qualify with fwd_we_o.
- Register write happens on the rising sys_clk edge when we = 1. Latency is one cycle to architectural state.
- x0: never written, always reads 0, including under bypass.
- Read ports:
  - Asynchronous read.
  - If we = 1 and rsN_addr_i == RD_addr_i != 0, rsN_data_o = fwd_data_o (same-cycle write-through, so decode never sees a stale value).
  - Otherwise rsN_data_o = stored value.
  - Both ports may hit the same address or bypass simultaneously.
- Counter:
  - On each rising edge with wb_valid_i = 1, instret_o += 1, regardless of RegWrite_i (stores and branches retire too).
  - Wraps modulo 2^CNT_W with no saturation or flag.
- Bubbles (wb_valid_i = 0) change no state, even if RegWrite_i = 1 from a flushed slot.
- Reset asserted mid-operation: state clears immediately, without waiting for a clock edge. A write coincident with the reset-release edge is dropped only if sys_rst is still high at that edge.
- No X propagation: all address decodes are full-case, and out-of-range addresses are impossible at NREG = 32.

Decomposition:
- Shared package holds:
  - XLEN, NREG, REG_AW = 5
  - write-back select encoding WB_SEL_ALU / WB_SEL_MEM / WB_SEL_LINK
  - register index constant X0 = 0
- One natural sub-module, regfile_2r1w: storage array, async reset, x0 hardwiring and bypass.
- The top holds the write-back mux, commit qualification and the instret counter.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read returns 0; instret_o = 0.
- Write path: valid=1, RegWrite=1, MemToReg=0, isjump=0, RD=5, ALU=0xDEADBEEF -> fwd_we=1 and fwd_data=0xDEADBEEF in the same cycle; next cycle rs1(5) = 0xDEADBEEF; instret = 1.
- Write-back select priority:
  - isjump=1, MemToReg=1, pc_link=0x104, mem=0x11, ALU=0x22 -> writes 0x104.
  - isjump=0, MemToReg=1 -> writes 0x11.
- Bypass: in the cycle that writes x7 = 0x1234, rs1=7 and rs2=7 -> both return 0x1234 before the clock edge.
- x0 protection: RegWrite=1 to RD=0 with ALU=0xFFFFFFFF -> fwd_we=0, rs1(0) stays 0, instret still increments. Bubble with RegWrite=1 to RD=3 -> x3 unchanged, instret unchanged.
- Async reset mid-stream: after writing x9 = 0xA5A5A5A5 and retiring 10 instructions, pulse sys_rst between clock edges -> x9 reads 0 and instret_o = 0 immediately. Counter preloaded near 2^64-1 by a force wraps to 0 after the increment.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_regfile_pkg
// Description : Shared constants and encodings for the write-back stage and
//               the architectural register file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_regfile_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   // Write-back source selection
   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_MEM  = 2'd1,
      WB_SEL_LINK = 2'd2
   } wb_sel_e;

   // Hardwired-zero register index
   localparam logic [REG_AW-1:0] X0 = '0;

endpackage

`default_nettype wire

// File: rtl/wb_regfile_regfile_2r1w.sv
//------------------------------------------------------------------------------
// Module      : regfile_2r1w
// Description : Two-read / one-write register array with asynchronous reset,
//               hardwired x0 and same-cycle write-through bypass on reads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = wb_regfile_pkg::XLEN,
   parameter int NREG = wb_regfile_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   logic [XLEN-1:0] regs [NREG];

   // Storage: cleared asynchronously, x0 is never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != X0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read port 1: x0 reads zero, otherwise bypass a same-cycle write
   always_comb begin
      rdata1 = regs[raddr1];
      if (raddr1 == X0) begin
         rdata1 = '0;
      end else if (we && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
   end

   // Read port 2: identical policy to port 1
   always_comb begin
      rdata2 = regs[raddr2];
      if (raddr2 == X0) begin
         rdata2 = '0;
      end else if (we && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
//------------------------------------------------------------------------------
// Module      : wb_regfile
// Description : Write-back stage: result select, commit qualification,
//               EX forwarding export, retired-instruction counter and the
//               architectural register file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int XLEN  = wb_regfile_pkg::XLEN,
   parameter int NREG  = wb_regfile_pkg::NREG,
   parameter int CNT_W = 64
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              wb_valid_i,
   input  logic [XLEN-1:0]   ALU_result_i,
   input  logic [XLEN-1:0]   DataMemReadData_i,
   input  logic [XLEN-1:0]   pc_link_i,
   input  logic [REG_AW-1:0] RD_addr_i,
   input  logic              RegWrite_i,
   input  logic              MemToReg_i,
   input  logic              isjump_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   output logic [XLEN-1:0]   rs1_data_o,
   output logic [XLEN-1:0]   rs2_data_o,
   output logic              fwd_we_o,
   output logic [REG_AW-1:0] fwd_addr_o,
   output logic [XLEN-1:0]   fwd_data_o,
   output logic [CNT_W-1:0]  instret_o
);

   wb_sel_e          wb_sel;
   logic [XLEN-1:0]  wb_data;
   logic             commit_we;
   logic [CNT_W-1:0] instret_q;

   // Source select: a jump link wins over load data, ALU is the fallback
   always_comb begin
      wb_sel = WB_SEL_ALU;
      if (isjump_i) begin
         wb_sel = WB_SEL_LINK;
      end else if (MemToReg_i) begin
         wb_sel = WB_SEL_MEM;
      end
   end

   // Write-back data mux, full case so no X can leak onto the result
   always_comb begin
      case (wb_sel)
         WB_SEL_LINK: wb_data = pc_link_i;
         WB_SEL_MEM:  wb_data = DataMemReadData_i;
         default:     wb_data = ALU_result_i;
      endcase
   end

   // Bubbles and x0 destinations never commit
   assign commit_we = wb_valid_i & RegWrite_i & (RD_addr_i != X0);

   assign fwd_we_o   = commit_we;
   assign fwd_addr_o = RD_addr_i;
   assign fwd_data_o = wb_data;

   // Retired-instruction counter: every valid slot retires, wraps silently
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         instret_q <= '0;
      end else if (wb_valid_i) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign instret_o = instret_q;

   regfile_2r1w #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .we     (commit_we),
      .waddr  (RD_addr_i),
      .wdata  (wb_data),
      .raddr1 (rs1_addr_i),
      .raddr2 (rs2_addr_i),
      .rdata1 (rs1_data_o),
      .rdata2 (rs2_data_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_regfile
// Description : Directed self-checking bench for wb_regfile.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;

   logic        sys_clk;
   logic        sys_rst;
   logic        wb_valid_i;
   logic [31:0] ALU_result_i;
   logic [31:0] DataMemReadData_i;
   logic [31:0] pc_link_i;
   logic [4:0]  RD_addr_i;
   logic        RegWrite_i;
   logic        MemToReg_i;
   logic        isjump_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic        fwd_we_o;
   logic [4:0]  fwd_addr_o;
   logic [31:0] fwd_data_o;
   logic [63:0] instret_o;

   wb_regfile dut (
      .sys_clk           (sys_clk),
      .sys_rst           (sys_rst),
      .wb_valid_i        (wb_valid_i),
      .ALU_result_i      (ALU_result_i),
      .DataMemReadData_i (DataMemReadData_i),
      .pc_link_i         (pc_link_i),
      .RD_addr_i         (RD_addr_i),
      .RegWrite_i        (RegWrite_i),
      .MemToReg_i        (MemToReg_i),
      .isjump_i          (isjump_i),
      .rs1_addr_i        (rs1_addr_i),
      .rs2_addr_i        (rs2_addr_i),
      .rs1_data_o        (rs1_data_o),
      .rs2_data_o        (rs2_data_o),
      .fwd_we_o          (fwd_we_o),
      .fwd_addr_o        (fwd_addr_o),
      .fwd_data_o        (fwd_data_o),
      .instret_o         (instret_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } sb_item_t;

   sb_item_t    sb[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [63:0] exp_cnt     = 64'd0;

   task automatic push(input string tag, input logic [63:0] v);
      sb_item_t it;
      it.tag = tag;
      it.exp = v;
      sb.push_back(it);
   endtask

   task automatic chk(input logic [63:0] obs);
      sb_item_t it;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp)
         else begin
            miscompares++;
            $error("FAIL %s observed=%h required=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   // Drive one write-back slot at the falling edge; outputs settle 1 ns later
   task automatic apply(input logic v, input logic rw, input logic m2r,
                        input logic jmp, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] lnk, input logic [4:0] a1,
                        input logic [4:0] a2);
      @(negedge sys_clk);
      wb_valid_i        = v;
      RegWrite_i        = rw;
      MemToReg_i        = m2r;
      isjump_i          = jmp;
      RD_addr_i         = rd;
      ALU_result_i      = alu;
      DataMemReadData_i = mem;
      pc_link_i         = lnk;
      rs1_addr_i        = a1;
      rs2_addr_i        = a2;
      #1;
   endtask

   // Cross a rising edge; the expected counter follows the valid flag
   task automatic tick();
      @(posedge sys_clk);
      if (wb_valid_i === 1'b1) exp_cnt = exp_cnt + 64'd1;
      #1;
   endtask

   task automatic read2(input logic [4:0] a1, input logic [4:0] a2);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, a1, a2);
   endtask

   initial begin
      sys_rst = 1'b1;
      wb_valid_i = 1'b0; RegWrite_i = 1'b0; MemToReg_i = 1'b0; isjump_i = 1'b0;
      RD_addr_i = 5'd0; ALU_result_i = '0; DataMemReadData_i = '0; pc_link_i = '0;
      rs1_addr_i = 5'd4; rs2_addr_i = 5'd31;
      #2;
      push("rst_rs1", 64'd0);     chk(64'(rs1_data_o));
      push("rst_rs2", 64'd0);     chk(64'(rs2_data_o));
      push("rst_instret", 64'd0); chk(instret_o);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // Every address reads zero on both ports after reset
      for (int i = 0; i < 32; i++) begin
         read2(5'(i), 5'(31 - i));
         push($sformatf("reset_rs1_x%0d", i), 64'd0);
         chk(64'(rs1_data_o));
         push($sformatf("reset_rs2_x%0d", 31 - i), 64'd0);
         chk(64'(rs2_data_o));
      end
      push("post_reset_instret", 64'd0); chk(instret_o);

      // Basic ALU write to x5
      apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 5'd1, 5'd2);
      push("wr5_fwd_we", 64'd1);            chk(64'(fwd_we_o));
      push("wr5_fwd_addr", 64'd5);          chk(64'(fwd_addr_o));
      push("wr5_fwd_data", 64'hDEADBEEF);   chk(64'(fwd_data_o));
      tick();
      read2(5'd5, 5'd0);
      push("x5_after", 64'hDEADBEEF);       chk(64'(rs1_data_o));
      push("x0_port2", 64'd0);              chk(64'(rs2_data_o));
      push("instret_1", exp_cnt);           chk(instret_o);

      // Select priority: jump link beats load data beats ALU
      apply(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h22, 32'h11, 32'h104, 5'd0, 5'd0);
      push("sel_link_fwd", 64'h104);        chk(64'(fwd_data_o));
      tick();
      apply(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h22, 32'h11, 32'h104, 5'd6, 5'd0);
      push("sel_mem_fwd", 64'h11);          chk(64'(fwd_data_o));
      push("x6_link", 64'h104);             chk(64'(rs1_data_o));
      tick();
      read2(5'd8, 5'd6);
      push("x8_mem", 64'h11);               chk(64'(rs1_data_o));
      push("x6_link_p2", 64'h104);          chk(64'(rs2_data_o));

      // Same-cycle write-through on both ports
      apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234, 32'h0, 32'h0, 5'd7, 5'd7);
      push("byp_rs1", 64'h1234);            chk(64'(rs1_data_o));
      push("byp_rs2", 64'h1234);            chk(64'(rs2_data_o));
      tick();
      read2(5'd7, 5'd5);
      push("x7_stored", 64'h1234);          chk(64'(rs1_data_o));
      push("x5_kept", 64'hDEADBEEF);        chk(64'(rs2_data_o));

      // x0 destination: no commit, no bypass, but the slot still retires
      apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
      push("x0_fwd_we", 64'd0);             chk(64'(fwd_we_o));
      push("x0_no_bypass", 64'd0);          chk(64'(rs1_data_o));
      tick();
      read2(5'd0, 5'd0);
      push("x0_after", 64'd0);              chk(64'(rs1_data_o));
      push("x0_instret", exp_cnt);          chk(instret_o);

      // Bubble carrying a stale RegWrite: no state change
      apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h55, 32'h0, 32'h0, 5'd3, 5'd0);
      push("bubble_fwd_we", 64'd0);         chk(64'(fwd_we_o));
      push("bubble_no_bypass", 64'd0);      chk(64'(rs1_data_o));
      tick();
      read2(5'd3, 5'd0);
      push("bubble_x3", 64'd0);             chk(64'(rs1_data_o));
      push("bubble_instret", exp_cnt);      chk(instret_o);

      // Write x9 then retire nine more non-writing instructions
      apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0BAD0BAD, 32'h0, 32'h0, 5'd9, 5'd0);
         tick();
      end
      read2(5'd9, 5'd7);
      push("x9_before_rst", 64'hA5A5A5A5);  chk(64'(rs1_data_o));
      push("instret_before_rst", exp_cnt);  chk(instret_o);

      // Asynchronous reset pulse between edges
      #1;
      sys_rst = 1'b1;
      #1;
      exp_cnt = 64'd0;
      push("async_x9", 64'd0);              chk(64'(rs1_data_o));
      push("async_x7", 64'd0);              chk(64'(rs2_data_o));
      push("async_instret", 64'd0);         chk(instret_o);
      #1;
      sys_rst = 1'b0;
      read2(5'd5, 5'd8);
      push("post_rst_x5", 64'd0);           chk(64'(rs1_data_o));
      push("post_rst_x8", 64'd0);           chk(64'(rs2_data_o));

      // Counter wrap from a preloaded near-maximum value
      @(negedge sys_clk);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.instret_q;
      exp_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      push("cnt_max", exp_cnt);             chk(instret_o);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      push("cnt_wrap", 64'd0);              chk(instret_o);
      push("cnt_wrap_model", exp_cnt);      chk(instret_o);

      read2(5'd0, 5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop so the run cannot hang
   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
